// File: rtl/game_sequencer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | game_sequencer_pkg : shared types and constants for the game FSM     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package game_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    LOAD_MASTER = 3'd1,
    WAIT_GUESS  = 3'd2,
    GRADE       = 3'd3,
    DONE        = 3'd4
  } state_t;

  typedef logic [2:0] shape_t;

  localparam int unsigned c_num_slots = 4;

  typedef logic [1:0] slot_t;

endpackage
`default_nettype wire

// File: rtl/game_sequencer_button_pulse.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | button_pulse : 2-flop synchronizer plus rising-edge pulse generator  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module button_pulse (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_pulse
);

  logic [1:0] r_sync;
  logic       r_prev;
  logic       r_pulse;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync  <= 2'b00;
      r_prev  <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], i_btn};
      r_prev  <= r_sync[1];
      r_pulse <= r_sync[1] & ~r_prev;
    end
  end

  assign o_pulse = r_pulse;

endmodule
`default_nettype wire

// File: rtl/game_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | game_sequencer : master-pattern entry and round sequencing for the   |
// | guessing game, driving an external grader. Rev 1.0                   |
// +----------------------------------------------------------------------+
module game_sequencer
  import game_sequencer_pkg::*;
#(
  parameter int MAX_ROUNDS  = 8,
  parameter int NUM_SYMBOLS = 6
) (
  input  logic       CLOCK_50,
  input  logic       reset_L,
  input  logic       StartGame,
  input  logic       MasterLoad,
  input  logic [2:0] MasterValue,
  input  logic       GradeIt,
  input  logic       gradeDone,
  input  logic [3:0] Znarly,
  input  logic [3:0] Zood,
  output logic [2:0] master0,
  output logic [2:0] master1,
  output logic [2:0] master2,
  output logic [2:0] master3,
  output logic       gradeStart,
  output logic       gamePlaying,
  output logic [3:0] RoundNumber,
  output logic [3:0] LastZnarly,
  output logic [3:0] LastZood,
  output logic       GameWon,
  output logic       GameOver
);

  localparam logic [3:0] c_max_rounds  = 4'(MAX_ROUNDS);
  localparam logic [3:0] c_num_symbols = 4'(NUM_SYMBOLS);
  localparam slot_t      c_slot_last   = slot_t'(c_num_slots - 1);

  logic   w_start;
  logic   w_load;
  logic   w_grade;
  logic   w_value_ok;
  logic [3:0] w_round_next;

  state_t r_state;
  slot_t  r_slot;
  shape_t r_master [c_num_slots];

  button_pulse u_start_pulse (
    .clk     (CLOCK_50),
    .rst_n   (reset_L),
    .i_btn   (StartGame),
    .o_pulse (w_start)
  );

  button_pulse u_load_pulse (
    .clk     (CLOCK_50),
    .rst_n   (reset_L),
    .i_btn   (MasterLoad),
    .o_pulse (w_load)
  );

  button_pulse u_grade_pulse (
    .clk     (CLOCK_50),
    .rst_n   (reset_L),
    .i_btn   (GradeIt),
    .o_pulse (w_grade)
  );

  assign w_value_ok   = ({1'b0, MasterValue} < c_num_symbols);
  assign w_round_next = RoundNumber + 4'd1;

  // StartGame takes priority in every state, which also covers abort/restart.
  always_ff @(posedge CLOCK_50 or negedge reset_L) begin
    if (!reset_L) begin
      r_state     <= IDLE;
      r_slot      <= '0;
      for (int i = 0; i < c_num_slots; i++) r_master[i] <= '0;
      RoundNumber <= '0;
      LastZnarly  <= '0;
      LastZood    <= '0;
      GameWon     <= 1'b0;
      GameOver    <= 1'b0;
      gradeStart  <= 1'b0;
    end else begin
      gradeStart <= 1'b0;
      if (w_start) begin
        r_state     <= LOAD_MASTER;
        r_slot      <= '0;
        for (int i = 0; i < c_num_slots; i++) r_master[i] <= '0;
        RoundNumber <= '0;
        LastZnarly  <= '0;
        LastZood    <= '0;
        GameWon     <= 1'b0;
        GameOver    <= 1'b0;
      end else begin
        case (r_state)
          LOAD_MASTER: begin
            if (w_load && w_value_ok) begin
              r_master[r_slot] <= MasterValue;
              r_slot           <= r_slot + 2'd1;
              if (r_slot == c_slot_last) r_state <= WAIT_GUESS;
            end
          end
          WAIT_GUESS: begin
            if (w_grade) begin
              gradeStart <= 1'b1;
              r_state    <= GRADE;
            end
          end
          GRADE: begin
            if (gradeDone) begin
              LastZnarly  <= Znarly;
              LastZood    <= Zood;
              RoundNumber <= w_round_next;
              if (Znarly == 4'd4) begin
                GameWon  <= 1'b1;
                GameOver <= 1'b1;
                r_state  <= DONE;
              end else if (w_round_next == c_max_rounds) begin
                GameOver <= 1'b1;
                r_state  <= DONE;
              end else begin
                r_state <= WAIT_GUESS;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign gamePlaying = (r_state == WAIT_GUESS) || (r_state == GRADE);
  assign master0     = r_master[0];
  assign master1     = r_master[1];
  assign master2     = r_master[2];
  assign master3     = r_master[3];

endmodule
`default_nettype wire

// File: tb/tb_game_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_game_sequencer : scoreboard bench for game_sequencer. Rev 1.0     |
// +----------------------------------------------------------------------+
module tb_game_sequencer;

  logic       CLOCK_50    = 1'b0;
  logic       reset_L     = 1'b0;
  logic       StartGame   = 1'b0;
  logic       MasterLoad  = 1'b0;
  logic [2:0] MasterValue = 3'd0;
  logic       GradeIt     = 1'b0;
  logic       gradeDone   = 1'b0;
  logic [3:0] Znarly      = 4'd0;
  logic [3:0] Zood        = 4'd0;
  logic [2:0] master0, master1, master2, master3;
  logic       gradeStart, gamePlaying, GameWon, GameOver;
  logic [3:0] RoundNumber, LastZnarly, LastZood;

  game_sequencer #(.MAX_ROUNDS(8), .NUM_SYMBOLS(6)) dut (
    .CLOCK_50    (CLOCK_50),
    .reset_L     (reset_L),
    .StartGame   (StartGame),
    .MasterLoad  (MasterLoad),
    .MasterValue (MasterValue),
    .GradeIt     (GradeIt),
    .gradeDone   (gradeDone),
    .Znarly      (Znarly),
    .Zood        (Zood),
    .master0     (master0),
    .master1     (master1),
    .master2     (master2),
    .master3     (master3),
    .gradeStart  (gradeStart),
    .gamePlaying (gamePlaying),
    .RoundNumber (RoundNumber),
    .LastZnarly  (LastZnarly),
    .LastZood    (LastZood),
    .GameWon     (GameWon),
    .GameOver    (GameOver)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int n_checks = 0;
  int n_errors = 0;
  int gs_count = 0;

  always @(negedge CLOCK_50) if (gradeStart) gs_count++;

  typedef struct {
    logic [3:0] zn, zo, rnd;
    logic       won, over, playing;
    int         gs;
  } exp_t;

  exp_t sb[$];

  logic [3:0] m_zn, m_zo, m_rnd;
  logic       m_won, m_over, m_wait, m_loading;
  logic [2:0] m_master [4];
  int         m_slot;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic set_btn(input int which, input logic v);
    case (which)
      0: StartGame  = v;
      1: MasterLoad = v;
      default: GradeIt = v;
    endcase
  endtask

  task automatic press(input int which, input int hold);
    @(negedge CLOCK_50);
    set_btn(which, 1'b1);
    cycles(hold);
    set_btn(which, 1'b0);
    cycles(6);
  endtask

  task automatic model_clear();
    m_zn = 0; m_zo = 0; m_rnd = 0; m_won = 0; m_over = 0; m_slot = 0;
    for (int i = 0; i < 4; i++) m_master[i] = 3'd0;
  endtask

  task automatic check_masters(input string tag);
    check({tag, "_m0"}, master0, m_master[0]);
    check({tag, "_m1"}, master1, m_master[1]);
    check({tag, "_m2"}, master2, m_master[2]);
    check({tag, "_m3"}, master3, m_master[3]);
  endtask

  task automatic check_status(input string tag);
    check({tag, "_round"}, RoundNumber, m_rnd);
    check({tag, "_lastzn"}, LastZnarly, m_zn);
    check({tag, "_lastzo"}, LastZood, m_zo);
    check({tag, "_won"}, GameWon, m_won);
    check({tag, "_over"}, GameOver, m_over);
    check({tag, "_playing"}, gamePlaying, m_wait);
  endtask

  task automatic restart(input string tag);
    press(0, 2);
    model_clear();
    m_loading = 1; m_wait = 0;
    check_masters(tag);
    check_status(tag);
  endtask

  task automatic load(input logic [2:0] v);
    MasterValue = v;
    press(1, 2);
    if (m_loading && v < 3'd6) begin
      m_master[m_slot] = v;
      m_slot++;
      if (m_slot == 4) begin m_loading = 0; m_wait = 1; end
    end
  endtask

  task automatic do_round(input string tag, input logic [3:0] zn, input logic [3:0] zo);
    exp_t e;
    int   gs0;
    gs0 = gs_count;
    if (m_wait) begin
      e.gs = 1; e.zn = zn; e.zo = zo; e.rnd = m_rnd + 4'd1;
      e.won = (zn == 4'd4);
      e.over = e.won || (e.rnd == 4'd8);
      e.playing = !e.over;
    end else begin
      e.gs = 0; e.zn = m_zn; e.zo = m_zo; e.rnd = m_rnd;
      e.won = m_won; e.over = m_over; e.playing = 1'b0;
    end
    sb.push_back(e);
    press(2, 2);
    @(negedge CLOCK_50);
    Znarly = zn; Zood = zo; gradeDone = 1'b1;
    @(negedge CLOCK_50);
    gradeDone = 1'b0; Znarly = 4'd0; Zood = 4'd0;
    cycles(2);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 1, 0);
    end else begin
      e = sb.pop_front();
      m_zn = e.zn; m_zo = e.zo; m_rnd = e.rnd;
      m_won = e.won; m_over = e.over; m_wait = e.playing;
      check({tag, "_gstart"}, gs_count - gs0, e.gs);
      check_status(tag);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int gs0;
    model_clear();
    m_wait = 0; m_loading = 0;
    cycles(3);
    check_masters("reset");
    check_status("reset");
    check("reset_gstart", gradeStart, 0);
    reset_L = 1'b1;
    cycles(2);

    // Out-of-range shape is dropped and the slot does not advance.
    restart("start1");
    load(3'd7);
    check_masters("ignore7");
    load(3'd2);
    load(3'd4);
    check_masters("load2_4");

    restart("start2");
    load(3'd3); load(3'd1); load(3'd5); load(3'd0);
    check_masters("load3150");
    check_status("load3150");

    do_round("r1", 4'd2, 4'd1);
    do_round("r2", 4'd1, 4'd3);
    do_round("r3win", 4'd4, 4'd0);
    do_round("afterwin", 4'd1, 4'd1);

    // Full loss: eight non-winning rounds, then a ninth attempt.
    restart("start3");
    load(3'd0); load(3'd1); load(3'd2); load(3'd3);
    for (int i = 0; i < 8; i++) do_round($sformatf("loss%0d", i), 4'(i % 4), 4'd2);
    do_round("ninth", 4'd3, 4'd1);

    // Held GradeIt and a repeat press inside GRADE give one gradeStart.
    restart("start4");
    load(3'd5); load(3'd4); load(3'd3); load(3'd2);
    gs0 = gs_count;
    press(2, 20);
    check("held_gstart", gs_count - gs0, 1);
    press(2, 2);
    check("repeat_gstart", gs_count - gs0, 1);
    check("grade_playing", gamePlaying, 1);
    restart("abort");
    do_round("post_abort", 4'd3, 4'd2);

    // Reset while grading discards the round.
    restart("start5");
    load(3'd1); load(3'd1); load(3'd2); load(3'd2);
    press(2, 2);
    @(negedge CLOCK_50);
    reset_L = 1'b0;
    cycles(3);
    reset_L = 1'b1;
    model_clear();
    m_wait = 0; m_loading = 0;
    check_masters("midreset");
    do_round("post_reset", 4'd4, 4'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/game_sequencer.md
GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 The module SHALL have parameter MAX_ROUNDS, default 8, meaning the number of graded rounds allowed before a loss.
REQ-002 The module SHALL have parameter NUM_SYMBOLS, default 6, meaning valid shape codes are 0..NUM_SYMBOLS-1.
REQ-003 The module SHALL have these ports:
- CLOCK_50  in  1  system clock, all logic on rising edge.
- reset_L  in  1  reset, asynchronous, active-low.
- StartGame  in  1  raw button; a rising edge begins master entry.
- MasterLoad  in  1  raw button; a rising edge captures MasterValue into the next master slot.
- MasterValue  in  3  shape code to load.
- GradeIt  in  1  raw button; a rising edge requests grading of the current guess.
- gradeDone  in  1  grader completion, 1-cycle pulse.
- Znarly, Zood  in  4 each  grader results, valid in the gradeDone cycle.
- master0..master3  out  3 each  stored master pattern.
- gradeStart  out  1  1-cycle pulse to the grader.
- gamePlaying  out  1  high in WAIT_GUESS and GRADE.
- RoundNumber  out  4  count of completed rounds.
- LastZnarly, LastZood  out  4 each  results of the most recent round.
- GameWon, GameOver  out  1 each  terminal flags.

Function
REQ-004 Each raw button SHALL pass through a 2-flop synchronizer followed by a rising-edge detector, producing a 1-cycle internal pulse 3 cycles after the input edge.
REQ-005 The FSM SHALL have states IDLE, LOAD_MASTER, WAIT_GUESS, GRADE and DONE.
REQ-006 IDLE: a StartGame pulse SHALL clear all masters, RoundNumber, Last* and flags, zero the slot index, and go to LOAD_MASTER.
REQ-007 LOAD_MASTER: on a MasterLoad pulse with MasterValue<NUM_SYMBOLS, the FSM SHALL write master[slot] and increment slot; a value >=NUM_SYMBOLS SHALL be ignored without advancing slot.
REQ-008 LOAD_MASTER: when the fourth slot is written, the FSM SHALL go to WAIT_GUESS on the next cycle.
REQ-009 WAIT_GUESS: a GradeIt pulse SHALL assert gradeStart for exactly one cycle and go to GRADE.
REQ-010 GRADE: GradeIt pulses SHALL be ignored (no queuing); on gradeDone the FSM SHALL latch Znarly/Zood into Last* and increment RoundNumber in the same edge.
REQ-011 In that same gradeDone edge: if Znarly==4, the FSM SHALL set GameWon and GameOver and go to DONE; else if the new RoundNumber==MAX_ROUNDS, it SHALL set GameOver only and go to DONE; else it SHALL return to WAIT_GUESS.
REQ-012 DONE: all outputs SHALL hold; a StartGame pulse SHALL behave as in IDLE (REQ-006).
REQ-013 A StartGame pulse in LOAD_MASTER, WAIT_GUESS or GRADE SHALL abort the game and restart as in REQ-006; a gradeDone arriving after the abort SHALL be ignored.
REQ-014 A gradeDone outside GRADE SHALL be ignored.
REQ-015 RoundNumber SHALL never exceed MAX_ROUNDS, and no wrap-around SHALL occur.
REQ-016 MasterLoad and GradeIt pulses in states where they have no defined effect SHALL be ignored.

Reset
REQ-017 While reset_L=0, the module SHALL force state to IDLE, and clear masters, slot, RoundNumber, Last*, GameWon, GameOver, gradeStart, gamePlaying and synchronizer flops to 0.
REQ-018 Reset assertion mid-grade SHALL discard the round, and the next gradeDone SHALL be ignored.

Structure
REQ-019 The state enum, the 3-bit shape type, and the constant for 4 master slots SHALL live in the shared game package.
REQ-020 One sub-module, button_pulse (synchronizer plus edge detector), SHALL be instantiated three times.

Verification
REQ-021 Reset, StartGame, load 3,1,5,0 -> master0..3=3,1,5,0, gamePlaying=1, RoundNumber=0.
REQ-022 In LOAD_MASTER, MasterValue=7 then 2 -> the 7 is ignored, master0=2, slot=1.
REQ-023 GradeIt, then gradeDone with Znarly=2, Zood=1 -> exactly one gradeStart pulse, LastZnarly=2, LastZood=1, RoundNumber=1, state WAIT_GUESS.
REQ-024 gradeDone with Znarly=4 in round 3 -> GameWon=1, GameOver=1, RoundNumber=3, and further GradeIt produces no gradeStart.
REQ-025 Eight non-winning rounds -> GameOver=1, GameWon=0, RoundNumber=8, and a ninth GradeIt is ignored.
REQ-026 GradeIt held high for 20 cycles, and a second GradeIt during GRADE -> one gradeStart only; StartGame mid-GRADE, then gradeDone -> Last* remain 0.
